// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//
// Multi-cycle fetch/decode/execute controller for the 8-bit DRF core.
// Walks every instruction through FETCH -> LATCH -> DECODE -> EXEC (-> MEM2)
// and raises the control strobes for PC, IR, register bank, ALU, memory bank
// selector and data memory. At most one BUS driver is enabled in any cycle.
//
// Ports
//   clk                  system clock, rising edge
//   rst                  synchronous active-high reset
//   in_IR[15:0]          instruction register: opcode[15:11], rx[10:8],
//                        ry[7:5], imm8[7:0], code address[8:0]
//   in_ALU_flags[3:0]    registered ALU flags {V, N, C, Z}
//   out_IR_load          IR captures code memory output
//   out_PC_inc           PC increments
//   out_PC_load          PC loads out_code_addr
//   out_code_addr[8:0]   jump target
//   out_REG_rx_sel[2:0]  register bank read select rx
//   out_REG_ry_sel[2:0]  register bank read select ry
//   out_REG_write_en     register bank writes BUS into rx
//   out_REG_enable_out   rx drives BUS
//   out_ALU_op[2:0]      ALU operation
//   out_ALU_enable_out   ALU result drives BUS
//   out_IMM_enable_out   imm8 drives BUS
//   out_MBS_wr_enable    bank selector loads out_MBS_data
//   out_MBS_data[1:0]    bank number
//   out_DMEM_addr_load   data memory latches BUS as low address byte
//   out_DMEM_wr_enable   data memory writes BUS
//   out_DMEM_enable_out  data memory drives BUS
//   out_halted           high while halted
//   out_illegal          one-cycle pulse on an undefined opcode in DECODE

module instruction_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_IR,
    input  logic [3:0]  in_ALU_flags,
    output logic        out_IR_load,
    output logic        out_PC_inc,
    output logic        out_PC_load,
    output logic [8:0]  out_code_addr,
    output logic [2:0]  out_REG_rx_sel,
    output logic [2:0]  out_REG_ry_sel,
    output logic        out_REG_write_en,
    output logic        out_REG_enable_out,
    output logic [2:0]  out_ALU_op,
    output logic        out_ALU_enable_out,
    output logic        out_IMM_enable_out,
    output logic        out_MBS_wr_enable,
    output logic [1:0]  out_MBS_data,
    output logic        out_DMEM_addr_load,
    output logic        out_DMEM_wr_enable,
    output logic        out_DMEM_enable_out,
    output logic        out_halted,
    output logic        out_illegal
);

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_CMP     = 5'b01000;
    localparam logic [OPC_W-1:0] OP_LDI     = 5'b01001;
    localparam logic [OPC_W-1:0] OP_LD      = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ST      = 5'b01011;
    localparam logic [OPC_W-1:0] OP_JMP     = 5'b10000;
    localparam logic [OPC_W-1:0] OP_JZ      = 5'b10001;
    localparam logic [OPC_W-1:0] OP_JNZ     = 5'b10010;
    localparam logic [OPC_W-1:0] OP_JC      = 5'b10011;
    localparam logic [OPC_W-1:0] OP_JN      = 5'b10100;
    localparam logic [OPC_W-1:0] OP_SETBANK = 5'b11000;
    localparam logic [OPC_W-1:0] OP_NOP     = 5'b11110;
    localparam logic [OPC_W-1:0] OP_HALT    = 5'b11111;

    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LATCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM2   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [OPC_W-1:0] opcode;
    logic             is_alu;
    logic             is_legal;
    logic             jcc_taken;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             unused_flag_v;

    // Instruction field decode
    assign opcode        = in_IR[15:11];
    assign is_alu        = (opcode[4:3] == 2'b00);
    assign flag_z        = in_ALU_flags[0];
    assign flag_c        = in_ALU_flags[1];
    assign flag_n        = in_ALU_flags[2];
    assign unused_flag_v = in_ALU_flags[3];

    // Defined opcodes; anything else decodes as illegal
    always_comb begin
        is_legal = is_alu;
        case (opcode)
            OP_CMP, OP_LDI, OP_LD, OP_ST,
            OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JN,
            OP_SETBANK, OP_NOP, OP_HALT: is_legal = 1'b1;
            default:                     ;
        endcase
    end

    // Branch condition on the flags presented in the current cycle
    always_comb begin
        jcc_taken = 1'b0;
        case (opcode)
            OP_JZ:   jcc_taken = flag_z;
            OP_JNZ:  jcc_taken = ~flag_z;
            OP_JC:   jcc_taken = flag_c;
            OP_JN:   jcc_taken = flag_n;
            default: jcc_taken = 1'b0;
        endcase
    end

    // Data fields follow the IR in every state so they never go X
    assign out_code_addr  = in_IR[8:0];
    assign out_REG_rx_sel = in_IR[10:8];
    assign out_REG_ry_sel = in_IR[7:5];
    assign out_MBS_data   = in_IR[1:0];
    assign out_ALU_op     = (opcode == OP_CMP) ? ALU_SUB : opcode[2:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and strobe decode
    always_comb begin
        state_nxt           = state;
        out_IR_load         = 1'b0;
        out_PC_inc          = 1'b0;
        out_PC_load         = 1'b0;
        out_REG_write_en    = 1'b0;
        out_REG_enable_out  = 1'b0;
        out_ALU_enable_out  = 1'b0;
        out_IMM_enable_out  = 1'b0;
        out_MBS_wr_enable   = 1'b0;
        out_DMEM_addr_load  = 1'b0;
        out_DMEM_wr_enable  = 1'b0;
        out_DMEM_enable_out = 1'b0;
        out_halted          = 1'b0;
        out_illegal         = 1'b0;

        case (state)
            // Code memory registers the word at PC
            S_FETCH: begin
                state_nxt = S_LATCH;
            end

            S_LATCH: begin
                out_IR_load = 1'b1;
                state_nxt   = S_DECODE;
            end

            // PC increments here so a taken jump in EXEC overrides it
            S_DECODE: begin
                out_PC_inc = 1'b1;
                if (opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                end else if (!is_legal) begin
                    out_illegal = 1'b1;
                    state_nxt   = S_FETCH;
                end else if (opcode == OP_NOP) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                state_nxt = S_FETCH;
                if (is_alu) begin
                    out_ALU_enable_out = 1'b1;
                    out_REG_write_en   = 1'b1;
                end else begin
                    case (opcode)
                        OP_CMP: ;  // flags only, result not written back
                        OP_LDI: begin
                            out_IMM_enable_out = 1'b1;
                            out_REG_write_en   = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            out_IMM_enable_out = 1'b1;
                            out_DMEM_addr_load = 1'b1;
                            state_nxt          = S_MEM2;
                        end
                        OP_JMP:     out_PC_load = 1'b1;
                        OP_JZ, OP_JNZ, OP_JC, OP_JN:
                                    out_PC_load = jcc_taken;
                        OP_SETBANK: out_MBS_wr_enable = 1'b1;
                        default:    ;
                    endcase
                end
            end

            // Data transfer phase of LD/ST, address latched in EXEC
            S_MEM2: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_LD: begin
                        out_DMEM_enable_out = 1'b1;
                        out_REG_write_en    = 1'b1;
                    end
                    OP_ST: begin
                        out_REG_enable_out = 1'b1;
                        out_DMEM_wr_enable = 1'b1;
                    end
                    default: ;
                endcase
            end

            // Only rst leaves HALT
            S_HALT: begin
                out_halted = 1'b1;
                state_nxt  = S_HALT;
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

endmodule
